vga_timing_gen: RTL

- Parametrised display timing and pixel generator. Replaces software bit-banging of rgb/hsync/vsync through general-purpose outputs.
- Generates VGA-style horizontal and vertical sync, data-enable, pixel coordinates and per-channel colour from programmable timing parameters.
- Supports four pixel sources: black, solid colour, colour bars, and an external pixel stream.
- Sits beside ibex_demo_system in the FPGA top; the top selects between its outputs and GPIO-driven video.

---
 rtl/vga_timing_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA-style timing and pixel generator: programmable porches/sync widths,
// pixel-clock divider and four pixel sources (black/solid/bars/external).
module vga_timing_gen #(
  parameter int HActive    = 640,
  parameter int HFront     = 16,
  parameter int HSync      = 96,
  parameter int HBack      = 48,
  parameter int VActive    = 480,
  parameter int VFront     = 10,
  parameter int VSync      = 2,
  parameter int VBack      = 33,
  parameter int ColourBits = 4,
  parameter int PixDiv     = 2,
  parameter bit HSyncPol   = 1'b0,
  parameter bit VSyncPol   = 1'b0,
  localparam int HTotal    = HActive + HFront + HSync + HBack,
  localparam int VTotal    = VActive + VFront + VSync + VBack,
  localparam int XW        = $clog2(HTotal),
  localparam int YW        = $clog2(VTotal),
  localparam int CW        = 3 * ColourBits
) (
  input  logic          clk_sys_i,
  input  logic          rst_sys_ni,
  input  logic          en_i,
  input  logic [1:0]    mode_i,
  input  logic [CW-1:0] colour_i,
  input  logic [CW-1:0] pix_i,
  output logic          pix_req_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          frame_start_o,
  output logic [CW-1:0] rgb_o
);

  localparam int DW = (PixDiv > 1) ? $clog2(PixDiv) : 1;

  localparam logic [DW-1:0] DEnd = DW'(PixDiv - 1);
  localparam logic [XW-1:0] HA   = XW'(HActive);
  localparam logic [XW-1:0] HEnd = XW'(HTotal - 1);
  localparam logic [XW-1:0] HS0  = XW'(HActive + HFront);
  localparam logic [XW-1:0] HS1  = XW'(HActive + HFront + HSync);
  localparam logic [XW-1:0] HBar = XW'(HActive / 8);
  localparam logic [YW-1:0] VA   = YW'(VActive);
  localparam logic [YW-1:0] VEnd = YW'(VTotal - 1);
  localparam logic [YW-1:0] VS0  = YW'(VActive + VFront);
  localparam logic [YW-1:0] VS1  = YW'(VActive + VFront + VSync);

  logic [DW-1:0] div_q, div_d;
  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] colour_q, colour_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          fs_q, fs_d;
  logic [CW-1:0] rgb_q, rgb_d;

  logic          run, stb, first;
  logic          active, hs, vs;
  logic [1:0]    mode_eff;
  logic [CW-1:0] colour_eff, bar_rgb;
  logic [2:0]    bar;

  always_comb begin
    run        = rst_sys_ni && en_i;
    stb        = run && (div_q == DEnd);
    first      = run && (h_q == '0) && (v_q == '0) && (div_q == '0);
    active     = (h_q < HA) && (v_q < VA);
    hs         = (h_q >= HS0) && (h_q < HS1);
    vs         = (v_q >= VS0) && (v_q < VS1);
    // Frame-entry sample must already steer pixel (0,0)
    mode_eff   = first ? mode_i : mode_q;
    colour_eff = first ? colour_i : colour_q;
    bar        = 3'(h_q / HBar);
    bar_rgb    = {{ColourBits{bar[2]}},
                  {ColourBits{bar[1]}},
                  {ColourBits{bar[0]}}};
    pix_req_o  = stb && active && (mode_eff == 2'd3);
  end

  always_comb begin
    div_d    = '0;
    h_d      = '0;
    v_d      = '0;
    mode_d   = mode_q;
    colour_d = colour_q;
    hsync_d  = ~HSyncPol;
    vsync_d  = ~VSyncPol;
    de_d     = 1'b0;
    x_d      = '0;
    y_d      = '0;
    fs_d     = 1'b0;
    rgb_d    = '0;
    if (!rst_sys_ni) begin
      mode_d   = '0;
      colour_d = '0;
    end else if (en_i) begin
      div_d = stb ? '0 : div_q + DW'(1);
      h_d   = h_q;
      v_d   = v_q;
      if (stb) begin
        h_d = (h_q == HEnd) ? '0 : h_q + XW'(1);
        if (h_q == HEnd) begin
          v_d = (v_q == VEnd) ? '0 : v_q + YW'(1);
        end
      end
      if (first) begin
        mode_d   = mode_i;
        colour_d = colour_i;
      end
      hsync_d = hs ? HSyncPol : ~HSyncPol;
      vsync_d = vs ? VSyncPol : ~VSyncPol;
      de_d    = active;
      x_d     = h_q;
      y_d     = v_q;
      fs_d    = first;
      if (active) begin
        unique case (mode_eff)
          2'd1:    rgb_d = colour_eff;
          2'd2:    rgb_d = bar_rgb;
          2'd3:    rgb_d = pix_req_o ? pix_i : rgb_q;
          default: rgb_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys_i) begin
    div_q    <= div_d;
    h_q      <= h_d;
    v_q      <= v_d;
    mode_q   <= mode_d;
    colour_q <= colour_d;
    hsync_q  <= hsync_d;
    vsync_q  <= vsync_d;
    de_q     <= de_d;
    x_q      <= x_d;
    y_q      <= y_d;
    fs_q     <= fs_d;
    rgb_q    <= rgb_d;
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign de_o          = de_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign frame_start_o = fs_q;
  assign rgb_o         = rgb_q;

endmodule
